// File: rtl/m2v_sched_pkg.sv
// Shared types and constants for the M2V job scheduler.
// Holds the FSM state enum, default geometry and the row-slice offset helper.
package m2v_pkg;

  localparam int DEF_DIMENSION = 16;
  localparam int DEF_WIDTH     = 8;

  typedef enum logic [2:0] {
    IDLE,
    LOAD,
    RUN,
    CAPT,
    RESP
  } m2v_state_t;

  // Bit offset of row 'row' inside the flattened matrix bus.
  function automatic int rowOffset(input int row, input int dimension, input int width);
    return row * dimension * width;
  endfunction

endpackage

// File: rtl/m2v_sched_if.sv
// Bundle of requester, load, engine and result signals around the M2V scheduler.
// The slave modport is the scheduler; the master modport is its environment.
interface m2v_sched_if import m2v_pkg::*; #(
  parameter int DIMENSION = DEF_DIMENSION,
  parameter int WIDTH     = DEF_WIDTH
) ();

  logic [1:0]                         req;
  logic [1:0]                         gnt;
  logic                               ld_valid;
  logic [DIMENSION*WIDTH-1:0]         ld_data;
  logic                               ld_ready;
  logic                               m_en;
  logic [DIMENSION*DIMENSION*WIDTH-1:0] m_mat;
  logic [DIMENSION*WIDTH-1:0]         m_vec;
  logic [DIMENSION*WIDTH-1:0]         m_mv;
  logic                               res_valid;
  logic [DIMENSION*WIDTH-1:0]         res_data;
  logic                               res_id;
  logic                               res_ready;

  modport master (
    output req, ld_valid, ld_data, m_mv, res_ready,
    input  gnt, ld_ready, m_en, m_mat, m_vec, res_valid, res_data, res_id
  );

  modport slave (
    input  req, ld_valid, ld_data, m_mv, res_ready,
    output gnt, ld_ready, m_en, m_mat, m_vec, res_valid, res_data, res_id
  );

endinterface

// File: rtl/m2v_sched_arb.sv
// Two-input round-robin arbiter; the pointer moves past the served requester
// when the job owner signals completion.
module rr_arb2 import m2v_pkg::*; (
  input  logic       clk,
  input  logic       rst,
  input  logic [1:0] req_i,
  input  logic       done_i,
  input  logic       doneId_i,
  output logic [1:0] gnt_o,
  output logic       winId_o
);

  logic ptr_q;
  logic ptr_d;

  always_comb begin
    winId_o = (req_i == 2'b11) ? ptr_q : req_i[1];
    gnt_o   = '0;
    if (req_i != 2'b00) gnt_o[winId_o] = 1'b1;
  end

  assign ptr_d = done_i ? ~doneId_i : ptr_q;

  always_ff @(posedge clk) begin
    if (!rst) ptr_q <= 1'b0;
    else      ptr_q <= ptr_d;
  end

endmodule

// File: rtl/m2v_sched.sv
// Job controller for the shared M2V engine: arbitrates two requesters, stages
// a matrix and vector from a beat stream, runs the engine and returns the result.
module m2v_sched import m2v_pkg::*; #(
  parameter int DIMENSION  = DEF_DIMENSION,
  parameter int WIDTH      = DEF_WIDTH,
  parameter int RUN_CYCLES = 32
) (
  input  logic           clk,
  input  logic           rst,
  m2v_sched_if.slave     bus
);

  localparam int ROW_W   = DIMENSION * WIDTH;
  localparam int MAT_W   = DIMENSION * ROW_W;
  localparam int CNT_MAX = (DIMENSION + 1 > RUN_CYCLES) ? DIMENSION + 1 : RUN_CYCLES;
  localparam int CNT_W   = $clog2(CNT_MAX + 1);

  m2v_state_t       state_q;
  logic [1:0]       gnt_q;
  logic             ldReady_q;
  logic             mEn_q;
  logic             resValid_q;
  logic             resId_q;
  logic [MAT_W-1:0] mat_q;
  logic [ROW_W-1:0] vec_q;
  logic [ROW_W-1:0] resData_q;
  logic [CNT_W-1:0] beatCnt_q;

  logic [1:0] arbGnt;
  logic       arbWin;
  logic       jobDone;

  assign jobDone = (state_q == RESP) && bus.res_ready;

  rr_arb2 uArb (
    .clk      (clk),
    .rst      (rst),
    .req_i    (bus.req),
    .done_i   (jobDone),
    .doneId_i (resId_q),
    .gnt_o    (arbGnt),
    .winId_o  (arbWin)
  );

  // beatCnt_q counts accepted beats in LOAD and enable cycles in RUN.
  always_ff @(posedge clk) begin
    if (!rst) begin
      state_q    <= IDLE;
      gnt_q      <= '0;
      ldReady_q  <= 1'b0;
      mEn_q      <= 1'b0;
      resValid_q <= 1'b0;
      resId_q    <= 1'b0;
      mat_q      <= '0;
      vec_q      <= '0;
      resData_q  <= '0;
      beatCnt_q  <= '0;
    end else begin
      case (state_q)
        IDLE: begin
          if (bus.req != 2'b00) begin
            gnt_q     <= arbGnt;
            resId_q   <= arbWin;
            ldReady_q <= 1'b1;
            beatCnt_q <= '0;
            state_q   <= LOAD;
          end
        end
        LOAD: begin
          if (bus.ld_valid) begin
            if (beatCnt_q == CNT_W'(DIMENSION)) begin
              vec_q     <= bus.ld_data;
              ldReady_q <= 1'b0;
              mEn_q     <= 1'b1;
              beatCnt_q <= '0;
              state_q   <= RUN;
            end else begin
              mat_q[rowOffset(int'(beatCnt_q), DIMENSION, WIDTH) +: ROW_W] <= bus.ld_data;
              beatCnt_q <= beatCnt_q + CNT_W'(1);
            end
          end
        end
        RUN: begin
          if (beatCnt_q == CNT_W'(RUN_CYCLES - 1)) begin
            mEn_q   <= 1'b0;
            state_q <= CAPT;
          end else begin
            beatCnt_q <= beatCnt_q + CNT_W'(1);
          end
        end
        // The engine output still holds the last enabled result this cycle.
        CAPT: begin
          resData_q  <= bus.m_mv;
          resValid_q <= 1'b1;
          state_q    <= RESP;
        end
        RESP: begin
          if (bus.res_ready) begin
            resValid_q <= 1'b0;
            gnt_q      <= '0;
            state_q    <= IDLE;
          end
        end
        default: state_q <= IDLE;
      endcase
    end
  end

  assign bus.gnt       = gnt_q;
  assign bus.ld_ready  = ldReady_q;
  assign bus.m_en      = mEn_q;
  assign bus.m_mat     = mat_q;
  assign bus.m_vec     = vec_q;
  assign bus.res_valid = resValid_q;
  assign bus.res_data  = resData_q;
  assign bus.res_id    = resId_q;

endmodule

// File: tb/tb_m2v_sched.sv
// Directed self-checking bench for m2v_sched with a registered engine stub
// that returns a fixed byte per lane while enabled and zero afterwards.
module tb_m2v_sched;
  import m2v_pkg::*;

  localparam int DIM  = 16;
  localparam int WID  = 8;
  localparam int RUNC = 32;
  localparam int ROWW = DIM * WID;
  localparam int MATW = DIM * ROWW;

  logic clk = 1'b0;
  logic rst = 1'b0;
  int assertions = 0;
  int failures = 0;

  logic [7:0]      stubVal = 8'h00;
  logic [ROWW-1:0] mvQ = '0;
  logic [ROWW-1:0] VEC;

  m2v_sched_if #(.DIMENSION(DIM), .WIDTH(WID)) bus ();

  m2v_sched #(.DIMENSION(DIM), .WIDTH(WID), .RUN_CYCLES(RUNC)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus.slave)
  );

  always #5 clk = ~clk;

  // Engine stub: MV is registered and zeroes one cycle after en drops.
  always_ff @(posedge clk) mvQ <= bus.m_en ? {DIM{stubVal}} : '0;
  assign bus.m_mv = mvQ;

  function automatic logic [ROWW-1:0] rowVal(input int r);
    logic [7:0] b;
    b = 8'(r + 1);
    return {DIM{b}};
  endfunction

  function automatic logic [MATW-1:0] expMat();
    logic [MATW-1:0] m;
    m = '0;
    for (int r = 0; r < DIM; r++) m[r*ROWW +: ROWW] = rowVal(r);
    return m;
  endfunction

  function automatic int rowsDiff(input logic [MATW-1:0] a, input logic [MATW-1:0] b);
    int n;
    n = 0;
    for (int r = 0; r < DIM; r++) if (a[r*ROWW +: ROWW] !== b[r*ROWW +: ROWW]) n++;
    return n;
  endfunction

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic doReset();
    rst = 1'b0;
    bus.req = 2'b00;
    bus.ld_valid = 1'b0;
    bus.ld_data = '0;
    bus.res_ready = 1'b1;
    tick();
    tick();
    rst = 1'b1;
  endtask

  task automatic requestJob(input logic [1:0] r, output logic [1:0] g, output int waitCycles);
    bus.req = r;
    waitCycles = 0;
    do begin
      tick();
      waitCycles++;
    end while (bus.gnt == 2'b00 && waitCycles < 200);
    g = bus.gnt;
  endtask

  task automatic loadBeats(input bit stall, output int cycles, output bit enSeen);
    int beat;
    bit toggle;
    bit valid;
    bit acc;
    beat = 0;
    cycles = 0;
    enSeen = 1'b0;
    toggle = 1'b0;
    while (beat <= DIM && cycles < 200) begin
      valid = stall ? toggle : 1'b1;
      bus.ld_valid = valid;
      bus.ld_data = (beat < DIM) ? rowVal(beat) : VEC;
      if (bus.m_en) enSeen = 1'b1;
      acc = valid && bus.ld_ready;
      tick();
      cycles++;
      toggle = ~toggle;
      if (acc) beat++;
    end
    bus.ld_valid = 1'b0;
  endtask

  task automatic runToResult(output int enCycles, output int capWait, output bit stable);
    enCycles = 0;
    capWait = 0;
    stable = 1'b1;
    while (bus.m_en && enCycles < 200) begin
      if (bus.m_mat !== expMat() || bus.m_vec !== VEC) stable = 1'b0;
      tick();
      enCycles++;
    end
    while (!bus.res_valid && capWait < 20) begin
      tick();
      capWait++;
    end
  endtask

  task automatic test_reset();
    doReset();
    assertions++; if (bus.gnt !== 2'b00) begin failures++; $display("[TB] FAIL reset_gnt: got %b want 00", bus.gnt); end
    assertions++; if (bus.ld_ready !== 1'b0) begin failures++; $display("[TB] FAIL reset_ld_ready: got %b want 0", bus.ld_ready); end
    assertions++; if (bus.m_en !== 1'b0) begin failures++; $display("[TB] FAIL reset_m_en: got %b want 0", bus.m_en); end
    assertions++; if (bus.res_valid !== 1'b0) begin failures++; $display("[TB] FAIL reset_res_valid: got %b want 0", bus.res_valid); end
    assertions++; if (bus.res_id !== 1'b0) begin failures++; $display("[TB] FAIL reset_res_id: got %b want 0", bus.res_id); end
    assertions++; if (rowsDiff(bus.m_mat, '0) != 0) begin failures++; $display("[TB] FAIL reset_m_mat: %0d rows nonzero, want 0", rowsDiff(bus.m_mat, '0)); end
    assertions++; if (bus.m_vec !== '0) begin failures++; $display("[TB] FAIL reset_m_vec: got %h want 0", bus.m_vec); end
    assertions++; if (bus.res_data !== '0) begin failures++; $display("[TB] FAIL reset_res_data: got %h want 0", bus.res_data); end
  endtask

  task automatic test_single_job();
    logic [1:0] g;
    int w, lc, enc, cw;
    bit en, st;
    doReset();
    stubVal = 8'h5A;
    requestJob(2'b01, g, w);
    assertions++; if (w != 1) begin failures++; $display("[TB] FAIL single_grant_latency: got %0d want 1", w); end
    assertions++; if (g !== 2'b01) begin failures++; $display("[TB] FAIL single_gnt: got %b want 01", g); end
    assertions++; if (bus.ld_ready !== 1'b1) begin failures++; $display("[TB] FAIL single_ld_ready: got %b want 1", bus.ld_ready); end
    bus.req = 2'b00;
    loadBeats(1'b0, lc, en);
    assertions++; if (lc != DIM + 1) begin failures++; $display("[TB] FAIL single_load_cycles: got %0d want %0d", lc, DIM + 1); end
    assertions++; if (en) begin failures++; $display("[TB] FAIL single_en_in_load: got 1 want 0"); end
    assertions++; if (rowsDiff(bus.m_mat, expMat()) != 0) begin failures++; $display("[TB] FAIL single_m_mat: %0d rows wrong, want 0", rowsDiff(bus.m_mat, expMat())); end
    assertions++; if (bus.m_vec !== VEC) begin failures++; $display("[TB] FAIL single_m_vec: got %h want %h", bus.m_vec, VEC); end
    runToResult(enc, cw, st);
    assertions++; if (enc != RUNC) begin failures++; $display("[TB] FAIL single_en_cycles: got %0d want %0d", enc, RUNC); end
    assertions++; if (!st) begin failures++; $display("[TB] FAIL single_stable: got unstable want stable"); end
    assertions++; if (lc + enc + cw != 50) begin failures++; $display("[TB] FAIL single_latency: got %0d want 50", lc + enc + cw); end
    assertions++; if (bus.res_data !== {DIM{8'h5A}}) begin failures++; $display("[TB] FAIL single_res_data: got %h want %h", bus.res_data, {DIM{8'h5A}}); end
    assertions++; if (bus.res_id !== 1'b0) begin failures++; $display("[TB] FAIL single_res_id: got %b want 0", bus.res_id); end
    tick();
    assertions++; if (bus.res_valid !== 1'b0) begin failures++; $display("[TB] FAIL single_resp_len: got %b want 0", bus.res_valid); end
    assertions++; if (bus.gnt !== 2'b00) begin failures++; $display("[TB] FAIL single_gnt_drop: got %b want 00", bus.gnt); end
  endtask

  task automatic test_contention();
    logic [1:0] g;
    logic [1:0] expG;
    int w, lc, enc, cw;
    bit en, st;
    doReset();
    for (int j = 0; j < 4; j++) begin
      stubVal = 8'(8'h20 + j);
      expG = (j % 2 == 1) ? 2'b10 : 2'b01;
      requestJob(2'b11, g, w);
      assertions++; if (w != 1) begin failures++; $display("[TB] FAIL contention_wait_%0d: got %0d want 1", j, w); end
      assertions++; if (g !== expG) begin failures++; $display("[TB] FAIL contention_gnt_%0d: got %b want %b", j, g, expG); end
      loadBeats(1'b0, lc, en);
      runToResult(enc, cw, st);
      assertions++; if (bus.res_id !== expG[1]) begin failures++; $display("[TB] FAIL contention_res_id_%0d: got %b want %b", j, bus.res_id, expG[1]); end
      assertions++; if (bus.res_data !== {DIM{8'(8'h20 + j)}}) begin failures++; $display("[TB] FAIL contention_res_data_%0d: got %h want %h", j, bus.res_data, {DIM{8'(8'h20 + j)}}); end
      tick();
      assertions++; if (bus.gnt !== 2'b00) begin failures++; $display("[TB] FAIL contention_idle_%0d: got %b want 00", j, bus.gnt); end
    end
    bus.req = 2'b00;
    tick();
  endtask

  task automatic test_load_stalls();
    logic [1:0] g;
    int w, lc, enc, cw;
    bit en, st;
    doReset();
    stubVal = 8'h33;
    requestJob(2'b01, g, w);
    bus.req = 2'b00;
    loadBeats(1'b1, lc, en);
    assertions++; if (lc != 34) begin failures++; $display("[TB] FAIL stall_load_cycles: got %0d want 34", lc); end
    assertions++; if (en) begin failures++; $display("[TB] FAIL stall_en_in_load: got 1 want 0"); end
    assertions++; if (bus.m_mat[15*ROWW +: ROWW] !== {DIM{8'h10}}) begin failures++; $display("[TB] FAIL stall_row15: got %h want %h", bus.m_mat[15*ROWW +: ROWW], {DIM{8'h10}}); end
    assertions++; if (bus.m_vec !== VEC) begin failures++; $display("[TB] FAIL stall_m_vec: got %h want %h", bus.m_vec, VEC); end
    runToResult(enc, cw, st);
    assertions++; if (bus.res_data !== {DIM{8'h33}}) begin failures++; $display("[TB] FAIL stall_res_data: got %h want %h", bus.res_data, {DIM{8'h33}}); end
    tick();
  endtask

  task automatic test_backpressure();
    logic [1:0] g;
    int w, lc, enc, cw;
    bit en, st;
    doReset();
    bus.res_ready = 1'b0;
    stubVal = 8'hC3;
    requestJob(2'b01, g, w);
    bus.req = 2'b10;
    loadBeats(1'b0, lc, en);
    runToResult(enc, cw, st);
    for (int i = 0; i < 10; i++) begin
      assertions++; if (bus.res_valid !== 1'b1) begin failures++; $display("[TB] FAIL bp_res_valid_%0d: got %b want 1", i, bus.res_valid); end
      assertions++; if (bus.res_data !== {DIM{8'hC3}}) begin failures++; $display("[TB] FAIL bp_res_data_%0d: got %h want %h", i, bus.res_data, {DIM{8'hC3}}); end
      assertions++; if (bus.gnt !== 2'b01) begin failures++; $display("[TB] FAIL bp_gnt_%0d: got %b want 01", i, bus.gnt); end
      tick();
    end
    bus.res_ready = 1'b1;
    tick();
    assertions++; if (bus.res_valid !== 1'b0) begin failures++; $display("[TB] FAIL bp_handshake_valid: got %b want 0", bus.res_valid); end
    assertions++; if (bus.gnt !== 2'b00) begin failures++; $display("[TB] FAIL bp_handshake_gnt: got %b want 00", bus.gnt); end
    tick();
    assertions++; if (bus.gnt !== 2'b10) begin failures++; $display("[TB] FAIL bp_next_gnt: got %b want 10", bus.gnt); end
    bus.req = 2'b00;
    loadBeats(1'b0, lc, en);
    runToResult(enc, cw, st);
    assertions++; if (bus.res_id !== 1'b1) begin failures++; $display("[TB] FAIL bp_next_res_id: got %b want 1", bus.res_id); end
    tick();
  endtask

  task automatic test_reset_mid_run();
    logic [1:0] g;
    int w, lc, enc, cw;
    bit en, st;
    doReset();
    stubVal = 8'h77;
    requestJob(2'b01, g, w);
    bus.req = 2'b00;
    loadBeats(1'b0, lc, en);
    for (int i = 0; i < 5; i++) tick();
    assertions++; if (bus.m_en !== 1'b1) begin failures++; $display("[TB] FAIL midrun_en_before: got %b want 1", bus.m_en); end
    rst = 1'b0;
    tick();
    assertions++; if (bus.m_en !== 1'b0) begin failures++; $display("[TB] FAIL midrun_m_en: got %b want 0", bus.m_en); end
    assertions++; if (bus.gnt !== 2'b00) begin failures++; $display("[TB] FAIL midrun_gnt: got %b want 00", bus.gnt); end
    assertions++; if (bus.res_valid !== 1'b0) begin failures++; $display("[TB] FAIL midrun_res_valid: got %b want 0", bus.res_valid); end
    assertions++; if (rowsDiff(bus.m_mat, '0) != 0) begin failures++; $display("[TB] FAIL midrun_m_mat: %0d rows nonzero, want 0", rowsDiff(bus.m_mat, '0)); end
    rst = 1'b1;
    requestJob(2'b10, g, w);
    assertions++; if (w != 1) begin failures++; $display("[TB] FAIL midrun_regrant_wait: got %0d want 1", w); end
    assertions++; if (g !== 2'b10) begin failures++; $display("[TB] FAIL midrun_regrant: got %b want 10", g); end
    bus.req = 2'b00;
    loadBeats(1'b0, lc, en);
    runToResult(enc, cw, st);
    assertions++; if (lc + enc + cw != 50) begin failures++; $display("[TB] FAIL midrun_latency: got %0d want 50", lc + enc + cw); end
    assertions++; if (bus.res_id !== 1'b1) begin failures++; $display("[TB] FAIL midrun_res_id: got %b want 1", bus.res_id); end
    assertions++; if (bus.res_data !== {DIM{8'h77}}) begin failures++; $display("[TB] FAIL midrun_res_data: got %h want %h", bus.res_data, {DIM{8'h77}}); end
    tick();
  endtask

  task automatic test_stray_beats();
    logic [1:0] g;
    int w, lc, enc, cw;
    bit en, st;
    doReset();
    stubVal = 8'h11;
    bus.ld_valid = 1'b1;
    bus.ld_data = {DIM{8'hEE}};
    for (int i = 0; i < 3; i++) begin
      tick();
      assertions++; if (bus.ld_ready !== 1'b0) begin failures++; $display("[TB] FAIL stray_idle_ready_%0d: got %b want 0", i, bus.ld_ready); end
    end
    assertions++; if (rowsDiff(bus.m_mat, '0) != 0 || bus.m_vec !== '0) begin failures++; $display("[TB] FAIL stray_idle_data: %0d rows changed, vec %h, want 0", rowsDiff(bus.m_mat, '0), bus.m_vec); end
    bus.ld_valid = 1'b0;
    requestJob(2'b01, g, w);
    bus.req = 2'b00;
    loadBeats(1'b0, lc, en);
    bus.ld_valid = 1'b1;
    bus.ld_data = {DIM{8'hEE}};
    for (int i = 0; i < 3; i++) begin
      tick();
      assertions++; if (bus.ld_ready !== 1'b0) begin failures++; $display("[TB] FAIL stray_run_ready_%0d: got %b want 0", i, bus.ld_ready); end
    end
    assertions++; if (rowsDiff(bus.m_mat, expMat()) != 0) begin failures++; $display("[TB] FAIL stray_run_m_mat: %0d rows wrong, want 0", rowsDiff(bus.m_mat, expMat())); end
    assertions++; if (bus.m_vec !== VEC) begin failures++; $display("[TB] FAIL stray_run_m_vec: got %h want %h", bus.m_vec, VEC); end
    bus.ld_valid = 1'b0;
    runToResult(enc, cw, st);
    assertions++; if (enc != RUNC - 3) begin failures++; $display("[TB] FAIL stray_run_remaining: got %0d want %0d", enc, RUNC - 3); end
    assertions++; if (bus.res_data !== {DIM{8'h11}}) begin failures++; $display("[TB] FAIL stray_res_data: got %h want %h", bus.res_data, {DIM{8'h11}}); end
    tick();
  endtask

  initial begin
    VEC = {DIM{8'h01}};
    bus.req = 2'b00;
    bus.ld_valid = 1'b0;
    bus.ld_data = '0;
    bus.res_ready = 1'b1;
    test_reset();
    test_single_job();
    test_contention();
    test_load_stalls();
    test_backpressure();
    test_reset_mid_run();
    test_stray_beats();
    $display("End of test - %0d assertions evaluated, %0d failures", assertions, failures);
    $finish;
  end

  initial begin
    #1ms;
    $display("[TB] FAIL watchdog: simulation time limit reached");
    $fatal(1, "[TB] watchdog expired");
  end

endmodule
